// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared types and defaults for the Fibonacci compute server.
//   state_t    : server FSM states (IDLE / RUN / RESP)
//   FIB_W      : default result width
//   FIB_IDX_W  : default term-index width
//   FIB_N_REQ  : number of requesters sharing the datapath
// No ports (package).
// -----------------------------------------------------------------------------
package fib_pkg;

  localparam int FIB_W     = 16;
  localparam int FIB_IDX_W = 5;
  localparam int FIB_N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index of the requester that is not g; used to hand priority over.
  function automatic logic other_req(input logic g);
    return ~g;
  endfunction

endpackage

// File: rtl/fib_server_if.sv
// -----------------------------------------------------------------------------
// fib_server_if
// Request/response bundle between client logic and fib_server.
//   req_valid [N]      : per-requester request valid       (client -> server)
//   req_ready [N]      : per-requester request accepted    (server -> client)
//   req_idx   [N][IDX] : per-requester term index n        (client -> server)
//   rsp_valid          : response valid                    (server -> client)
//   rsp_ready          : response consumed                 (client -> server)
//   rsp_id             : requester owning the response     (server -> client)
//   rsp_data  [W]      : F(n) mod 2^W                      (server -> client)
//   rsp_ovf            : true F(n) >= 2^W                  (server -> client)
// Modports: master = client side, slave = server side.
// -----------------------------------------------------------------------------
interface fib_server_if
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int IDX_W = FIB_IDX_W
) ();

  logic [FIB_N_REQ-1:0]            req_valid;
  logic [FIB_N_REQ-1:0]            req_ready;
  logic [FIB_N_REQ-1:0][IDX_W-1:0] req_idx;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic                            rsp_id;
  logic [W-1:0]                    rsp_data;
  logic                            rsp_ovf;

  modport master (
    output req_valid,
    output req_idx,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data,
    input  rsp_ovf
  );

  modport slave (
    input  req_valid,
    input  req_idx,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_data,
    output rsp_ovf
  );

endinterface

// File: rtl/fib_server_chk.sv
// -----------------------------------------------------------------------------
// fib_server_chk
// Protocol checker for the request side: a requester that is waiting
// (valid high, not yet granted) must hold its term index unchanged.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_req_valid  : per-requester valid
//   i_req_ready  : per-requester ready as driven by the server
//   i_req_idx    : per-requester term index
// -----------------------------------------------------------------------------
module fib_server_chk
  import fib_pkg::*;
#(
  parameter int IDX_W = FIB_IDX_W
) (
  input logic                            clk,
  input logic                            rst,
  input logic [FIB_N_REQ-1:0]            i_req_valid,
  input logic [FIB_N_REQ-1:0]            i_req_ready,
  input logic [FIB_N_REQ-1:0][IDX_W-1:0] i_req_idx
);

  for (genvar gi = 0; gi < FIB_N_REQ; gi++) begin : g_req
    a_idx_stable: assert property (
      @(posedge clk) disable iff (rst)
      (i_req_valid[gi] && !i_req_ready[gi]) |=> (i_req_idx[gi] == $past(i_req_idx[gi]))
    );
  end

endmodule

// File: rtl/fib_server_step.sv
// -----------------------------------------------------------------------------
// fib_step
// Combinational Fibonacci stepping datapath with exact overflow tracking.
// (a, b) hold two consecutive terms; b runs one term ahead, so each register
// carries its own "true value >= 2^W" flag.
// Build option: FIB_SERVER_DOUBLE_RATE_EN -- when defined, i_double_en selects
// a two-term advance (a, b) <- (a+b, a+2b); when undefined only the single
// step exists and the second adder is not built.
// Ports:
//   i_a, i_b          : current terms (mod 2^W)
//   i_a_ovf, i_b_ovf  : overflow flags of the current terms
//   i_double_en       : request a two-term advance
//   o_a, o_b          : next terms
//   o_a_ovf, o_b_ovf  : overflow flags of the next terms
//   o_two_steps       : the two-term advance was taken
// -----------------------------------------------------------------------------
module fib_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_a_ovf,
  input  logic         i_b_ovf,
  input  logic         i_double_en,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b,
  output logic         o_a_ovf,
  output logic         o_b_ovf,
  output logic         o_two_steps
);

  // a + b with its carry in the top bit
  logic [W:0] w_sum_ab;
  assign w_sum_ab = {1'b0, i_a} + {1'b0, i_b};

`ifdef FIB_SERVER_DOUBLE_RATE_EN
  // (a + b) + b, built on the wrapped first sum
  logic [W:0] w_sum_abb;
  assign w_sum_abb = {1'b0, w_sum_ab[W-1:0]} + {1'b0, i_b};

  // Select single or double advance
  always_comb begin
    o_a         = i_b;
    o_b         = w_sum_ab[W-1:0];
    o_a_ovf     = i_b_ovf;
    o_b_ovf     = i_a_ovf | i_b_ovf | w_sum_ab[W];
    o_two_steps = 1'b0;
    if (i_double_en) begin
      o_a         = w_sum_ab[W-1:0];
      o_b         = w_sum_abb[W-1:0];
      o_a_ovf     = i_a_ovf | i_b_ovf | w_sum_ab[W];
      o_b_ovf     = i_a_ovf | i_b_ovf | w_sum_ab[W] | w_sum_abb[W];
      o_two_steps = 1'b1;
    end else begin
      o_two_steps = 1'b0;
    end
  end
`else
  // Double-rate request has no effect in this build
  logic w_unused_double_en;
  assign w_unused_double_en = i_double_en;

  // Single advance only: a takes b's value and flag, b takes the new sum
  always_comb begin
    o_a         = i_b;
    o_b         = w_sum_ab[W-1:0];
    o_a_ovf     = i_b_ovf;
    o_b_ovf     = i_a_ovf | i_b_ovf | w_sum_ab[W];
    o_two_steps = 1'b0;
  end
`endif

endmodule

// File: rtl/fib_server.sv
// -----------------------------------------------------------------------------
// fib_server
// Shared Fibonacci compute server (F(0)=F(1)=1). Two requesters submit a term
// index; a round-robin arbiter grants one at a time, a single stepping
// datapath (fib_step) iterates to the term, and the result returns on one
// tagged response channel with an exact overflow flag.
// Build option: FIB_SERVER_DOUBLE_RATE_EN (handled inside fib_step) advances
// two terms per RUN cycle while at least two steps remain.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : fib_server_if.slave request/response bundle
// -----------------------------------------------------------------------------
module fib_server
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int IDX_W = FIB_IDX_W
) (
  input logic         clk,
  input logic         rst,
  fib_server_if.slave bus
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_prio;
  logic                 w_grant;
  logic [FIB_N_REQ-1:0] w_req_ready;
  logic                 w_accept;

  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic                 r_a_ovf;
  logic                 r_b_ovf;
  logic [IDX_W-1:0]     r_cnt;
  logic                 r_id;

  logic                 r_rsp_valid;
  logic [W-1:0]         r_rsp_data;
  logic                 r_rsp_ovf;
  logic                 r_rsp_id;

  logic [W-1:0]         w_next_a;
  logic [W-1:0]         w_next_b;
  logic                 w_next_a_ovf;
  logic                 w_next_b_ovf;
  logic                 w_double_en;
  logic                 w_two_steps;
  logic [IDX_W-1:0]     w_cnt_dec;
  logic                 w_cnt_zero;

  assign w_cnt_zero  = (r_cnt == IDX_W'(1'b0));
  assign w_double_en = (r_cnt >= IDX_W'(2'd2));
  assign w_cnt_dec   = w_two_steps ? IDX_W'(2'd2) : IDX_W'(1'd1);

  fib_step #(.W(W)) u_step (
    .i_a         (r_a),
    .i_b         (r_b),
    .i_a_ovf     (r_a_ovf),
    .i_b_ovf     (r_b_ovf),
    .i_double_en (w_double_en),
    .o_a         (w_next_a),
    .o_b         (w_next_b),
    .o_a_ovf     (w_next_a_ovf),
    .o_b_ovf     (w_next_b_ovf),
    .o_two_steps (w_two_steps)
  );

  // Round-robin pick: a lone requester wins, a tie goes to r_prio
  always_comb begin
    w_grant = 1'b0;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = r_prio;
      default: w_grant = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = RUN;
        else          w_next_state = IDLE;
      end
      RUN: begin
        if (w_cnt_zero) w_next_state = RESP;
        else            w_next_state = RUN;
      end
      RESP: begin
        if (bus.rsp_ready) w_next_state = IDLE;
        else               w_next_state = RESP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: ready only for the granted requester, only in IDLE
  always_comb begin
    w_req_ready = '0;
    if (r_state == IDLE && (|bus.req_valid)) begin
      w_req_ready[w_grant] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
    w_accept = |(w_req_ready & bus.req_valid);
  end

  // Priority pointer flips to the other requester after every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_accept) begin
      r_prio <= other_req(w_grant);
    end else begin
      r_prio <= r_prio;
    end
  end

  // Datapath registers: load on accept, step while terms remain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= W'(1'b1);
      r_b     <= W'(1'b1);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
      r_cnt   <= IDX_W'(1'b0);
      r_id    <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_a     <= W'(1'b1);
      r_b     <= W'(1'b1);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
      r_cnt   <= bus.req_idx[w_grant];
      r_id    <= w_grant;
    end else if (r_state == RUN && !w_cnt_zero) begin
      r_a     <= w_next_a;
      r_b     <= w_next_b;
      r_a_ovf <= w_next_a_ovf;
      r_b_ovf <= w_next_b_ovf;
      r_cnt   <= r_cnt - w_cnt_dec;
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_a_ovf <= r_a_ovf;
      r_b_ovf <= r_b_ovf;
      r_cnt   <= r_cnt;
    end
  end

  // Response registers: captured at the end of RUN, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= W'(1'b0);
      r_rsp_ovf   <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else if (r_state == RUN && w_cnt_zero) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= r_a;
      r_rsp_ovf   <= r_a_ovf;
      r_rsp_id    <= r_id;
    end else if (r_state == RESP && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_ovf   = r_rsp_ovf;
  assign bus.rsp_id    = r_rsp_id;

  fib_server_chk #(.IDX_W(IDX_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (bus.req_valid),
    .i_req_ready (w_req_ready),
    .i_req_idx   (bus.req_idx)
  );

endmodule
